ext_bus_target: RTL and testbench

- Responder on the HS32 external multiplexed 16-bit address/data bus; sits on the far side of the CPU's external SRAM/bus master.
- Demultiplexes the two address phases, decodes against a window, and converts each bus cycle into a single-request local memory handshake.
- Returns read data onto the shared bus while OE is high.
- Used for FPGA-side peripherals/RAM and as the synthesizable bus model in system benches.

---
 rtl/ext_bus_pkg.sv | 25 ++
 rtl/ext_bus_decode.sv | 27 ++
 rtl/ext_bus_target.sv | 220 ++++++++++++++++++++++
 tb/tb_ext_bus_target.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the HS32 external multiplexed address/data bus.
// Used by both the bus target and the CPU-side bus master.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        DATA,
        WREQ,
        RREQ,
        RDRIVE
    } state_t;

    localparam int BLE_BIT = 15;
    localparam int HI_W    = 15;
    localparam int LO_W    = 16;

    // Byte address is {addr[31:17], addr[16:1], addr[0]}
    function automatic logic [31:0] assemble_addr(input logic [HI_W-1:0] hi,
                                                  input logic [LO_W-1:0] lo,
                                                  input logic            a0);
        return {hi, lo, a0};
    endfunction

endpackage

// File: rtl/ext_bus_decode.sv
// Combinational window compare plus byte-enable / address bit 0 derivation.
module ext_bus_decode
    import ext_bus_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter logic [31:0] MASK = 32'hFFFF_0000
) (
    input  logic [HI_W-1:0] i_hi,
    input  logic [LO_W-1:0] i_lo,
    input  logic            i_ble,
    input  logic            i_bhe,
    output logic            o_hit,
    output logic [1:0]      o_be,
    output logic            o_a0
);

    localparam logic [31:0] CMP_MASK = MASK & 32'hFFFF_FFFE;

    logic [31:0] w_addr;

    assign w_addr = assemble_addr(i_hi, i_lo, 1'b0);
    assign o_hit  = ((w_addr & CMP_MASK) == (BASE & CMP_MASK));
    assign o_be   = {i_bhe, i_ble};
    // A lone high-byte access addresses the odd byte
    assign o_a0   = i_bhe & ~i_ble;

endmodule

// File: rtl/ext_bus_target.sv
// HS32 external bus responder: demultiplexes address phases, decodes a window
// and turns each bus cycle into one local memory request.
module ext_bus_target
    import ext_bus_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter logic [31:0] MASK = 32'hFFFF_0000,
    parameter int          ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     bus_din,
    output logic [15:0]     bus_dout,
    output logic            bus_drive,
    input  logic            ale0,
    input  logic            ale1,
    input  logic            we,
    input  logic            oe,
    input  logic            bhe,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_rw,
    output logic [31:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    output logic [1:0]      mem_be,
    input  logic [15:0]     mem_rdata,
    output logic            hit,
    output logic [ERRW-1:0] err_cnt
);

    state_t            r_state, w_state_nxt;
    logic [LO_W-1:0]   r_lo, w_lo_nxt;
    logic [HI_W-1:0]   r_hi, w_hi_nxt;
    logic              r_ble, w_ble_nxt;
    logic              r_hit, w_hit_nxt;
    logic              r_missed, w_missed_nxt;
    logic              r_drive, w_drive_nxt;
    logic [15:0]       r_dout, w_dout_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_rw, w_rw_nxt;
    logic [31:0]       r_addr, w_addr_nxt;
    logic [15:0]       r_wdata, w_wdata_nxt;
    logic [1:0]        r_be, w_be_nxt;
    logic [ERRW-1:0]   r_err;
    logic              w_err_inc;

    logic              w_hit;
    logic [1:0]        w_be;
    logic              w_a0;
    logic [HI_W-1:0]   w_dec_hi;

    // The window compare needs the high phase while it is still on the bus
    assign w_dec_hi = (r_state == ADDR_HI) ? bus_din[HI_W-1:0] : r_hi;

    ext_bus_decode #(
        .BASE (BASE),
        .MASK (MASK)
    ) u_decode (
        .i_hi  (w_dec_hi),
        .i_lo  (r_lo),
        .i_ble (r_ble),
        .i_bhe (bhe),
        .o_hit (w_hit),
        .o_be  (w_be),
        .o_a0  (w_a0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_ble    <= 1'b0;
            r_hit    <= 1'b0;
            r_missed <= 1'b0;
            r_drive  <= 1'b0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_ble    <= w_ble_nxt;
            r_hit    <= w_hit_nxt;
            r_missed <= w_missed_nxt;
            r_drive  <= w_drive_nxt;
            r_dout   <= w_dout_nxt;
            r_valid  <= w_valid_nxt;
            r_rw     <= w_rw_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_be     <= w_be_nxt;
            if (w_err_inc && (r_err != {ERRW{1'b1}})) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_ble_nxt    = r_ble;
        w_hit_nxt    = r_hit;
        w_missed_nxt = r_missed;
        w_drive_nxt  = r_drive;
        w_dout_nxt   = r_dout;
        w_valid_nxt  = r_valid;
        w_rw_nxt     = r_rw;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_be_nxt     = r_be;
        w_err_inc    = 1'b0;

        case (r_state)
            IDLE: begin
                w_hit_nxt    = 1'b0;
                w_missed_nxt = 1'b0;
                if (ale0) begin
                    w_lo_nxt    = bus_din;
                    w_state_nxt = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (ale0) begin
                    w_lo_nxt = bus_din;
                end else if (ale1) begin
                    w_ble_nxt   = bus_din[BLE_BIT];
                    w_hi_nxt    = bus_din[HI_W-1:0];
                    w_hit_nxt   = w_hit;
                    w_state_nxt = w_hit ? DATA : IDLE;
                end
            end
            DATA: begin
                if (ale0) begin
                    w_lo_nxt    = bus_din;
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = ADDR_HI;
                end else if (we) begin
                    if (r_ble || bhe) begin
                        w_wdata_nxt = bus_din;
                        w_be_nxt    = w_be;
                        w_addr_nxt  = assemble_addr(r_hi, r_lo, w_a0);
                        w_rw_nxt    = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = WREQ;
                    end else begin
                        w_err_inc   = 1'b1;
                        w_hit_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else if (oe) begin
                    w_rw_nxt    = 1'b0;
                    w_be_nxt    = 2'b11;
                    w_addr_nxt  = assemble_addr(r_hi, r_lo, 1'b0);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = RREQ;
                end
            end
            WREQ: begin
                w_err_inc = ale0;
                if (mem_ready) begin
                    w_valid_nxt = 1'b0;
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            RREQ: begin
                // A missed deadline is counted once, the request still completes
                w_err_inc = ale0 || (!oe && !r_missed);
                if (mem_ready) begin
                    w_valid_nxt = 1'b0;
                    if (oe && !r_missed) begin
                        w_dout_nxt  = mem_rdata;
                        w_drive_nxt = 1'b1;
                        w_state_nxt = RDRIVE;
                    end else begin
                        w_hit_nxt    = 1'b0;
                        w_missed_nxt = 1'b0;
                        w_state_nxt  = IDLE;
                    end
                end else if (!oe) begin
                    w_missed_nxt = 1'b1;
                end
            end
            RDRIVE: begin
                if (we || ale0 || ale1) begin
                    w_err_inc   = 1'b1;
                    w_drive_nxt = 1'b0;
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (!oe) begin
                    w_drive_nxt = 1'b0;
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gating with the bus strobes releases the pins in the same cycle a conflict appears
    assign bus_drive = r_drive & ~(we | ale0 | ale1);
    assign bus_dout  = r_dout;
    assign mem_valid = r_valid;
    assign mem_rw    = r_rw;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign hit       = r_hit;
    assign err_cnt   = r_err;

endmodule

// File: tb/tb_ext_bus_target.sv
// Directed self-checking bench for ext_bus_target (window BASE=0, MASK=F000_0000).
module tb_ext_bus_target;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic        bus_drive;
    logic        ale0;
    logic        ale1;
    logic        we;
    logic        oe;
    logic        bhe;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;
    logic        hit;
    logic [7:0]  err_cnt;

    int passCount;
    int failCount;
    int checkCount;

    ext_bus_target #(
        .BASE (32'h0000_0000),
        .MASK (32'hF000_0000),
        .ERRW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_drive (bus_drive),
        .ale0      (ale0),
        .ale1      (ale1),
        .we        (we),
        .oe        (oe),
        .bhe       (bhe),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .hit       (hit),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Two address phases; leaves the ALE lines low afterwards
    task automatic applyStimulus(input logic [15:0] lo, input logic [15:0] hiPhase);
        ale0    = 1'b1;
        bus_din = lo;
        step();
        ale0    = 1'b0;
        ale1    = 1'b1;
        bus_din = hiPhase;
        step();
        ale1    = 1'b0;
    endtask

    initial begin
        passCount  = 0;
        failCount  = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        bus_din    = '0;
        ale0       = 1'b0;
        ale1       = 1'b0;
        we         = 1'b0;
        oe         = 1'b0;
        bhe        = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        checkOutput("reset_drive", bus_drive, 0);
        checkOutput("reset_valid", mem_valid, 0);
        checkOutput("reset_addr", mem_addr, 0);
        checkOutput("reset_be", mem_be, 0);
        checkOutput("reset_hit", hit, 0);
        checkOutput("reset_err", err_cnt, 0);
        rst_n = 1'b1;
        step();

        // Word read at lo=0x0012, hi=0
        applyStimulus(16'h0012, 16'h0000);
        checkOutput("rd_hit", hit, 1);
        oe      = 1'b1;
        bus_din = 16'h0000;
        step();
        checkOutput("rd_valid", mem_valid, 1);
        checkOutput("rd_rw", mem_rw, 0);
        checkOutput("rd_addr", mem_addr, 32'h0000_0024);
        checkOutput("rd_be", mem_be, 2'b11);
        checkOutput("rd_drive_early", bus_drive, 0);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ready = 1'b0;
        checkOutput("rd_drive", bus_drive, 1);
        checkOutput("rd_dout", bus_dout, 16'hBEEF);
        checkOutput("rd_valid_drop", mem_valid, 0);
        step();
        checkOutput("rd_drive_hold", bus_drive, 1);
        oe = 1'b0;
        step();
        checkOutput("rd_drive_release", bus_drive, 0);
        checkOutput("rd_hit_clear", hit, 0);

        // Low-byte write
        applyStimulus(16'h0004, 16'h8000);
        we      = 1'b1;
        bhe     = 1'b0;
        bus_din = 16'h00A5;
        step();
        we = 1'b0;
        checkOutput("wl_valid", mem_valid, 1);
        checkOutput("wl_rw", mem_rw, 1);
        checkOutput("wl_addr", mem_addr, 32'h0000_0008);
        checkOutput("wl_be", mem_be, 2'b01);
        checkOutput("wl_wdata", mem_wdata, 16'h00A5);
        step();
        checkOutput("wl_hold_valid", mem_valid, 1);
        checkOutput("wl_hold_addr", mem_addr, 32'h0000_0008);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checkOutput("wl_done", mem_valid, 0);

        // High-byte write at lo=0x0010, hi=1
        applyStimulus(16'h0010, 16'h0001);
        we      = 1'b1;
        bhe     = 1'b1;
        bus_din = 16'h5A00;
        step();
        we  = 1'b0;
        bhe = 1'b0;
        checkOutput("wh_addr", mem_addr, 32'h0002_0021);
        checkOutput("wh_be", mem_be, 2'b10);
        checkOutput("wh_wdata", mem_wdata, 16'h5A00);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checkOutput("wh_done", mem_valid, 0);

        // Miss: address 0x1000_0000 lies outside the window
        applyStimulus(16'h0000, 16'h0800);
        checkOutput("miss_hit", hit, 0);
        oe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("miss_valid", mem_valid, 0);
            checkOutput("miss_drive", bus_drive, 0);
        end
        oe = 1'b0;
        step();

        // Deadline miss: oe falls while ready is still low
        applyStimulus(16'h0001, 16'h0000);
        oe = 1'b1;
        step();
        checkOutput("dl_addr", mem_addr, 32'h0000_0002);
        oe = 1'b0;
        step();
        checkOutput("dl_err", err_cnt, 1);
        checkOutput("dl_valid_held", mem_valid, 1);
        step();
        checkOutput("dl_err_once", err_cnt, 1);
        mem_ready = 1'b1;
        mem_rdata = 16'h1111;
        step();
        mem_ready = 1'b0;
        checkOutput("dl_valid_drop", mem_valid, 0);
        checkOutput("dl_drive", bus_drive, 0);
        step();
        checkOutput("dl_drive_after", bus_drive, 0);

        // Write with no byte enables counts an error and issues nothing
        applyStimulus(16'h0002, 16'h0000);
        we  = 1'b1;
        bhe = 1'b0;
        step();
        we = 1'b0;
        checkOutput("nobe_err", err_cnt, 2);
        checkOutput("nobe_valid", mem_valid, 0);

        // Reset asserted while driving read data
        applyStimulus(16'h0005, 16'h0000);
        oe = 1'b1;
        step();
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        step();
        mem_ready = 1'b0;
        checkOutput("rst_pre_drive", bus_drive, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_drive", bus_drive, 0);
        checkOutput("rst_async_err", err_cnt, 0);
        oe = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Clean read after reset at lo=0x0030
        applyStimulus(16'h0030, 16'h0000);
        oe = 1'b1;
        step();
        checkOutput("post_addr", mem_addr, 32'h0000_0060);
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ready = 1'b0;
        checkOutput("post_drive", bus_drive, 1);
        checkOutput("post_dout", bus_dout, 16'h1234);
        oe = 1'b0;
        step();
        checkOutput("post_release", bus_drive, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
